// File: rtl/csr_tohost_drain.sv
// csr_tohost_drain
// Captures CSR writes to the tohost address into a small FIFO and drains each
// captured 32-bit word as a byte stream (LSB first) over valid/ready.
//
// Optional build macro: CSR_DRAIN_SYNC_EN
//   defined   - each frame is prefixed with sync byte 8'hA5 (5-byte frames)
//   undefined - SYNC state compiled out (4-byte frames)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   csr_we/addr/wdata   CSR write port tapped from the core
//   tx_data, tx_valid   registered byte stream towards the UART
//   tx_ready            sink ready; byte accepted on tx_valid && tx_ready
//   last_value          most recent captured write (including dropped ones)
//   count               buffered words, excluding the word being sent
//   overflow            sticky, set when a write is dropped on a full FIFO
//
// state  | meaning
// IDLE   | no frame in flight; pops the head word when count != 0
// SYNC   | presenting sync byte 8'hA5 (CSR_DRAIN_SYNC_EN only)
// BYTE   | presenting shift register byte selected by idx
`timescale 1ns/1ps
module csr_tohost_drain #(
  parameter logic [11:0] CSR_ADDR   = 12'h51E,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          csr_we,
  input  logic [11:0]                   csr_addr,
  input  logic [31:0]                   csr_wdata,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [31:0]                   last_value,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef CSR_DRAIN_SYNC_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_BYTE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_BYTE} state_t;
`endif

  state_t        state, state_nx;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   shreg, shreg_nx;
  logic [1:0]    idx, idx_nx;
  logic          valid_nx;
  logic [7:0]    data_nx;
  logic          hit, full, push, pop;

  assign hit  = csr_we && (csr_addr == CSR_ADDR);
  assign full = (count == FULL_CNT);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push = hit && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= csr_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      last_value <= 32'h0;
    end else begin
      if (hit) last_value <= csr_wdata;
      if (hit && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= 32'h0;
      idx      <= 2'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      idx      <= idx_nx;
      tx_valid <= valid_nx;
      tx_data  <= data_nx;
    end
  end

  // Outputs are computed from the next state so they can be registered
  // without an extra cycle of latency.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          shreg_nx = mem[rd_ptr];
          idx_nx   = 2'd0;
`ifdef CSR_DRAIN_SYNC_EN
          state_nx = ST_SYNC;
`else
          state_nx = ST_BYTE;
`endif
        end
      end
`ifdef CSR_DRAIN_SYNC_EN
      ST_SYNC: begin
        if (tx_ready) state_nx = ST_BYTE;
      end
`endif
      ST_BYTE: begin
        if (tx_ready) begin
          if (idx == 2'd3) state_nx = ST_IDLE;
          else             idx_nx   = idx + 2'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    valid_nx = 1'b0;
    data_nx  = 8'h00;
    case (state_nx)
`ifdef CSR_DRAIN_SYNC_EN
      ST_SYNC: begin
        valid_nx = 1'b1;
        data_nx  = 8'hA5;
      end
`endif
      ST_BYTE: begin
        valid_nx = 1'b1;
        data_nx  = shreg_nx[{idx_nx, 3'b000} +: 8];
      end
      default: begin
        valid_nx = 1'b0;
        data_nx  = 8'h00;
      end
    endcase
  end

endmodule

// File: doc/csr_tohost_drain.md
# csr_tohost_drain

Consumer side of the CPU's CSR write path. Watches the core's CSR write strobe, captures every write to the `tohost` CSR into a small FIFO, and drains each captured 32-bit word as a byte stream over a valid/ready interface. That stream feeds the UART transmitter, so software can report test status off-chip. It sits beside `Riscv151`, tapping the same CSRW write port the core uses to update its CSR register.

## Interface
Parameters:
- `CSR_ADDR`, default 12'h51E: CSR address that is captured.
- `FIFO_DEPTH`, default 4: number of buffered words; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `csr_we`  in  1  CSR write strobe from the core, one cycle per write.
- `csr_addr`  in  12  CSR address of the write.
- `csr_wdata`  in  32  CSR write data.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid && tx_ready` at a clock edge.
- `last_value`  out  32  most recent captured write, including dropped writes.
- `count`  out  $clog2(FIFO_DEPTH)+1  number of words in the FIFO, excluding the word being sent.
- `overflow`  out  1  sticky; set when a write is dropped because the FIFO is full.

## Operation
- Capture happens on a clock edge with `csr_we && csr_addr == CSR_ADDR`:
  - `last_value` is always updated with `csr_wdata`.
  - If the FIFO is not full, the word is pushed.
  - Otherwise the word is dropped and `overflow` is set.
- Writes to any other address are ignored.
- FIFO uses circular read/write pointers of width $clog2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from `count`.
- Serializer FSM:
  - IDLE: `tx_valid` = 0. If `count` != 0, pop the head word into a 32-bit shift register, clear the byte index, and go to SYNC (macro defined) or BYTE (macro undefined).
  - SYNC: `tx_data` = 8'hA5, `tx_valid` = 1. On handshake, go to BYTE.
  - BYTE: `tx_data` = shift register byte selected by the index, least-significant byte first; `tx_valid` = 1. On handshake, increment the index. After the handshake on index 3, go to IDLE.
- Back-to-back frames: frames always pass through IDLE for one cycle. The gap is one cycle with `tx_valid` = 0.
- Simultaneous push and pop:
  - Full FIFO: the pop frees a slot and the push is accepted. `overflow` is not set and `count` is unchanged.
  - Empty FIFO: there is no bypass. The word is pushed and popped on a later IDLE cycle.
- `tx_data` and `tx_valid` are held stable while `tx_valid && !tx_ready`. `tx_valid` never deasserts without a handshake.
- `overflow` clears only on reset.

## Timing
- Reset is asynchronous. While `rst_n` = 0: FSM in IDLE, `tx_valid` = 0, `tx_data` = 8'h00, `count` = 0, `overflow` = 0, `last_value` = 32'h0, pointers = 0.
- Reset mid-frame discards the frame and all buffered words immediately, with no pending handshake.
- Capture latency: a matching write sampled at edge N appears in `count` and `last_value` after edge N.
- Output latency: with an empty FIFO and FSM in IDLE, a write at edge N is popped at edge N+1. `tx_valid` is high from edge N+1 with the first byte (sync byte or byte 0).
- Frame throughput with `tx_ready` held at 1:
  - Macro defined: 5 cycles of `tx_valid` per word, plus 1 idle cycle.
  - Macro undefined: 4 cycles of `tx_valid` per word, plus 1 idle cycle.
- All outputs are registered. No combinational path from `tx_ready` to `tx_valid` or `tx_data`.

## Configuration
- `CSR_DRAIN_SYNC_EN` defined: each frame is prefixed with sync byte 8'hA5 (SYNC state present), so frames are 5 bytes.
- `CSR_DRAIN_SYNC_EN` undefined: the SYNC state is compiled out and frames are 4 bytes. All other behaviour is identical.

## Test plan
- Reset then write 100 to 0x51E, `tx_ready` = 1 → `last_value` = 100 one edge later. Bytes 0x64, 0x00, 0x00, 0x00 (preceded by 0xA5 if the macro is defined). `count` returns to 0.
- Write 0x12345678 to 0x300 → no `count` change, `last_value` unchanged, `tx_valid` stays 0.
- `tx_ready` = 0, write 16 then 32 → `tx_valid` held with the first byte stable for 10 cycles; `count` = 1. Raise `tx_ready` → both frames sent in order, with a 1-cycle gap between them.
- `tx_ready` = 0, write 1..6 with FIFO_DEPTH = 4 → first word in the shift register, words 2–5 buffered (`count` = 4), word 6 dropped. `overflow` = 1, `last_value` = 6. Drain yields 1, 2, 3, 4, 5.
- Full FIFO, and a pop coincides with a matching write → `count` stays 4 and `overflow` stays 0.
- Assert `rst_n` low during byte 2 of a frame with 2 words buffered → `tx_valid` falls with no clock edge. After release, `count` = 0 and no further bytes are emitted.
